sc_reset_request: RTL and testbench
===================================

// Module: sc_reset_request
// PURPOSE
//  Generates SC_RESET_STATEMACHINEGENERAL_InHigh: the game-level restart request that the reset combiner ORs with the board reset.
//  - Debounces the raw START button.
//  - Emits a fixed-length, active-high reset request pulse.
//  - Holds off re-triggering for a cooldown window, then reports completion.
//  - Clock and reset come from the raw board reset only, never from the combined reset output (that would form a self-reset loop).
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable cycles before a START level change is accepted (>=1)
//  PULSE_CYCLES     8   cycles REQUEST_OUT is held high (>=1)
//  COOLDOWN_CYCLES  16  cycles after the pulse during which triggers are dropped (>=1)
//  CNT_WIDTH        20  shared counter width; must hold max(DEBOUNCE,PULSE,COOLDOWN)_CYCLES
// PORTS
//  SC_RESETREQ_CLOCK_50       in   1  50 MHz system clock
//  SC_RESETREQ_RESET_InHigh   in   1  synchronous, active-high reset (board reset)
//  SC_RESETREQ_START_InLow    in   1  raw asynchronous START button, active-low
//  SC_RESETREQ_GAMEOVER_InHigh in  1  game-over level from the main game FSM
//  SC_RESETREQ_REQUEST_OUT    out  1  restart request; drives the reset combiner's state-machine input
//  SC_RESETREQ_BUSY_OUT       out  1  high in ASSERT and COOLDOWN
//  SC_RESETREQ_DONE_OUT       out  1  1-cycle pulse on COOLDOWN->IDLE
// BEHAVIOUR
//  Reset and clocking
//  - One clock. Reset is synchronous and active-high; it wins over every other event.
//  - Reset values: REQUEST 0, BUSY 0, DONE 0, state IDLE, counters 0.
//  - START sync flops 1, debounced START 1, gameover_prev 1. A GAMEOVER held high through reset does not trigger.
//  - Reset mid-ASSERT drops REQUEST on the reset edge. No DONE is emitted.
//  START input path
//  - START passes through a 2-flop synchronizer.
//  - Debounce counter increments while the synced level differs from the debounced level, and clears on a match.
//  - On reaching DEBOUNCE_CYCLES it loads the new debounced level and clears.
//  - press event = debounced level 1->0 on this edge (registered, 1 cycle). Release generates no event.
//  Triggering
//  - trigger = press event (OR GAMEOVER rising edge, see CONFIGURATION).
//  - Simultaneous sources give a single trigger.
//  FSM (registered outputs)
//  - IDLE: trigger -> ASSERT. Next edge REQUEST=1, BUSY=1, counter=0.
//  - ASSERT: counter++. At PULSE_CYCLES-1 -> COOLDOWN with REQUEST=0 next edge.
//    REQUEST is high exactly PULSE_CYCLES cycles.
//  - COOLDOWN: counter++. At COOLDOWN_CYCLES-1 -> IDLE with BUSY=0 and DONE=1 for one cycle.
//  - Triggers in ASSERT or COOLDOWN are dropped, not queued.
//  - A press in the IDLE cycle where DONE is high is accepted.
//  Latency and arithmetic
//  - START held low from edge 0 -> REQUEST high at edge 2+DEBOUNCE_CYCLES+1.
//  - Trigger -> REQUEST is 1 edge.
//  - Counters are unsigned, compared for equality, and never wrap within legal parameters.
//  - Bounce shorter than DEBOUNCE_CYCLES never changes the debounced level.
// CONFIGURATION
//  SC_RESETREQ_AUTORESTART_EN
//  - Defined: a GAMEOVER 0->1 edge (GAMEOVER high, gameover_prev low) also triggers from IDLE.
//  - Undefined: GAMEOVER is ignored, gameover_prev logic is removed, and only a START press triggers.
//  - Ports are identical in both builds.
// TESTING (DEBOUNCE=4, PULSE=8, COOLDOWN=16)
//  1. START 1->0 at edge 10, held -> REQUEST high edges 17..24, BUSY 17..40, DONE single cycle at edge 41.
//  2. START glitches low 3 cycles, then high -> REQUEST never asserts, debounced level stays 1.
//  3. Second press during COOLDOWN -> ignored; exactly one REQUEST pulse of 8 cycles, one DONE.
//  4. RESET asserted at 3rd cycle of ASSERT -> REQUEST/BUSY 0 on that edge, IDLE, no DONE; a later press works normally.
//  5. AUTORESTART_EN defined: GAMEOVER 0->1 at edge 5 -> REQUEST high edges 6..13; GAMEOVER high through reset -> no trigger.
//  6. AUTORESTART_EN undefined: GAMEOVER toggling -> REQUEST stays 0; START press still yields an 8-cycle pulse.

Source files
------------

// File: rtl/sc_reset_request.sv
// sc_reset_request: game-level restart request generator.
// Debounces the raw active-low START button, emits a fixed-length
// active-high REQUEST pulse, then enforces a cooldown window before
// reporting DONE. Clocked and reset from the raw board reset only.
// Optional feature macro: SC_RESETREQ_AUTORESTART_EN -- when defined, a
// rising edge on GAMEOVER also triggers a request from IDLE.
module sc_reset_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_WIDTH       = 20
) (
  input  logic SC_RESETREQ_CLOCK_50,
  input  logic SC_RESETREQ_RESET_InHigh,
  input  logic SC_RESETREQ_START_InLow,
  input  logic SC_RESETREQ_GAMEOVER_InHigh,
  output logic SC_RESETREQ_REQUEST_OUT,
  output logic SC_RESETREQ_BUSY_OUT,
  output logic SC_RESETREQ_DONE_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  logic                 clk;
  logic                 rst;
  logic                 start_sync_p0;
  logic                 start_sync_p1;
  logic                 start_deb;
  logic [CNT_WIDTH-1:0] deb_cnt;
  logic                 press_p2;
  logic                 trigger;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 request_d;
  logic                 busy_d;
  logic                 done_d;

  assign clk = SC_RESETREQ_CLOCK_50;
  assign rst = SC_RESETREQ_RESET_InHigh;

  // Two-flop synchronizer for the asynchronous START button (idles high)
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync_p0 <= 1'b1;
      start_sync_p1 <= 1'b1;
    end else begin
      start_sync_p0 <= SC_RESETREQ_START_InLow;
      start_sync_p1 <= start_sync_p0;
    end
  end

  // Debounce: accept a level change after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; a 1->0 acceptance is registered as a press event
  always_ff @(posedge clk) begin
    if (rst) begin
      start_deb <= 1'b1;
      deb_cnt   <= '0;
      press_p2  <= 1'b0;
    end else begin
      press_p2 <= 1'b0;
      if (deb_cnt == CNT_WIDTH'(DEBOUNCE_CYCLES)) begin
        start_deb <= ~start_deb;
        press_p2  <= start_deb;
        deb_cnt   <= '0;
      end else if (start_sync_p1 != start_deb) begin
        deb_cnt <= deb_cnt + CNT_WIDTH'(1);
      end else begin
        deb_cnt <= '0;
      end
    end
  end

`ifdef SC_RESETREQ_AUTORESTART_EN
  logic gameover_prev;
  logic gameover_rise_p0;

  // GAMEOVER rising-edge detector; prev resets high so a level held
  // through reset is not mistaken for a new edge
  always_ff @(posedge clk) begin
    if (rst) begin
      gameover_prev    <= 1'b1;
      gameover_rise_p0 <= 1'b0;
    end else begin
      gameover_prev    <= SC_RESETREQ_GAMEOVER_InHigh;
      gameover_rise_p0 <= SC_RESETREQ_GAMEOVER_InHigh & ~gameover_prev;
    end
  end

  assign trigger = press_p2 | gameover_rise_p0;
`else
  logic unused_gameover;
  assign unused_gameover = SC_RESETREQ_GAMEOVER_InHigh;
  assign trigger         = press_p2;
`endif

  // State register with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ST_IDLE;
      cnt                     <= '0;
      SC_RESETREQ_REQUEST_OUT <= 1'b0;
      SC_RESETREQ_BUSY_OUT    <= 1'b0;
      SC_RESETREQ_DONE_OUT    <= 1'b0;
    end else begin
      state                   <= state_next;
      cnt                     <= cnt_next;
      SC_RESETREQ_REQUEST_OUT <= request_d;
      SC_RESETREQ_BUSY_OUT    <= busy_d;
      SC_RESETREQ_DONE_OUT    <= done_d;
    end
  end

  // Next-state logic; triggers outside IDLE are simply dropped
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end
      end
      ST_ASSERT: begin
        if (cnt == CNT_WIDTH'(PULSE_CYCLES - 1)) begin
          state_next = ST_COOLDOWN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      ST_COOLDOWN: begin
        if (cnt == CNT_WIDTH'(COOLDOWN_CYCLES - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, registered above
  always_comb begin
    request_d = (state_next == ST_ASSERT);
    busy_d    = (state_next == ST_ASSERT) || (state_next == ST_COOLDOWN);
    done_d    = (state == ST_COOLDOWN) && (state_next == ST_IDLE);
  end

endmodule

// File: tb/tb_sc_reset_request.sv
// tb_sc_reset_request: randomized self-checking bench for sc_reset_request.
// The reference model predicts outputs from the start time of the active
// pulse and from windows of sampled START history.
module tb_sc_reset_request;

  localparam int DEB = 4;
  localparam int P   = 8;
  localparam int C   = 16;

  logic clk;
  logic rst;
  logic start_n;
  logic gameover;
  logic req;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;

  sc_reset_request #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (P),
    .COOLDOWN_CYCLES(C),
    .CNT_WIDTH      (20)
  ) dut (
    .SC_RESETREQ_CLOCK_50       (clk),
    .SC_RESETREQ_RESET_InHigh   (rst),
    .SC_RESETREQ_START_InLow    (start_n),
    .SC_RESETREQ_GAMEOVER_InHigh(gameover),
    .SC_RESETREQ_REQUEST_OUT    (req),
    .SC_RESETREQ_BUSY_OUT       (busy),
    .SC_RESETREQ_DONE_OUT       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int  e         = 0;
  bit  s_hist [0:16383];
  bit  m_deb     = 1'b1;
  int  m_barrier = 0;
  bit  m_press   = 1'b0;
  bit  m_rise    = 1'b0;
  bit  m_goprev  = 1'b1;
  bit  m_active  = 1'b0;
  int  m_t       = 0;
  bit  exp_req, exp_busy, exp_done;
  int  n_pulses  = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0b expected %0b", tag, e - 1, got, exp);
    end
  endtask

  // Advance the model by one clock edge with the inputs sampled there
  task automatic model_edge(input bit r, input bit st, input bit g);
    bit trig;
    bit idle;
    bit all_diff;
    trig = m_press | m_rise;
    idle = !m_active || (e - 1 >= m_t + P + C);
    if (r) begin
      m_active  = 1'b0;
      m_press   = 1'b0;
      m_rise    = 1'b0;
      m_deb     = 1'b1;
      m_barrier = e;
      m_goprev  = 1'b1;
      s_hist[e] = 1'b1;
    end else begin
      if (trig && idle) begin
        m_active = 1'b1;
        m_t      = e;
        n_pulses++;
      end
      s_hist[e] = st;
      m_press   = 1'b0;
      // A level is accepted once DEB consecutive synced samples disagree
      // with the debounced level; the sample seen at edge k is START from k-2
      if (e - (DEB + 2) >= m_barrier) begin
        all_diff = 1'b1;
        for (int k = e - (DEB + 2); k <= e - 3; k++)
          if (s_hist[k] == m_deb) all_diff = 1'b0;
        if (all_diff) begin
          m_deb     = !m_deb;
          m_barrier = e - 1;
          m_press   = !m_deb;
        end
      end
`ifdef SC_RESETREQ_AUTORESTART_EN
      m_rise   = g & !m_goprev;
      m_goprev = g;
`else
      m_rise   = 1'b0;
`endif
    end
    exp_req  = m_active && (e >= m_t) && (e < m_t + P);
    exp_busy = m_active && (e < m_t + P + C);
    exp_done = m_active && (e == m_t + P + C);
    e++;
  endtask

  // Drive one cycle from the falling edge, check just after the rising edge
  task automatic drive_cycle(input bit r, input bit st, input bit g);
    rst      = r;
    start_n  = st;
    gameover = g;
    @(posedge clk);
    model_edge(r, st, g);
    #1;
    check_eq("request", req,  exp_req);
    check_eq("busy",    busy, exp_busy);
    check_eq("done",    done, exp_done);
    @(negedge clk);
  endtask

  initial begin
    int  seg_left;
    bit  seg_val;
    int  mode;
    int  rst_left;
    bit  go_lvl;
    bit  st;

    rst = 1'b1; start_n = 1'b1; gameover = 1'b1;
    @(negedge clk);

    // Reset with GAMEOVER held high
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b1);

    // Clean press: START low sampled from the 10th edge after reset
    for (int i = 0; i < 9; i++)  drive_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, 1'b1);

    // Glitches shorter than the debounce window
    for (int n = 1; n < DEB; n++) begin
      for (int i = 0; i < n; i++)  drive_cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    end

    // Second press during cooldown
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1, 1'b0);

    // Reset during the third ASSERT cycle, then a normal press
    for (int i = 0; i < 9; i++)  drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1, 1'b0);

    // GAMEOVER rising edge from IDLE
    for (int i = 0; i < 4; i++)  drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  drive_cycle(1'b0, 1'b1, 1'b0);

    // Randomized segments of presses, glitches, bounce, resets, GAMEOVER
    seg_left = 0; seg_val = 1'b1; rst_left = 0; go_lvl = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (seg_left == 0) begin
        mode = int'($urandom_range(0, 3));
        case (mode)
          0: begin seg_val = 1'b0; seg_left = int'($urandom_range(1, DEB)); end
          1: begin seg_val = 1'b0; seg_left = int'($urandom_range(DEB + 1, 40)); end
          2: begin seg_val = 1'b1; seg_left = int'($urandom_range(1, 50)); end
          default: begin seg_val = 1'bx; seg_left = int'($urandom_range(1, 12)); end
        endcase
      end
      st = (seg_val === 1'bx) ? 1'($urandom_range(0, 1)) : seg_val;
      seg_left--;
      if (rst_left == 0 && $urandom_range(0, 399) == 0)
        rst_left = int'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) go_lvl = !go_lvl;
      drive_cycle(rst_left != 0, st, go_lvl);
      if (rst_left != 0) rst_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
